// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bus between the T-state control sequencer and the datapath.
// The sequencer consumes instruction/stall/flag_z and produces the registered
// state code, T-index, latched opcode and status flags.
// The irq/irq_ack pair exists only when CTRL_IRQ_EN is defined.
interface control_sequencer_if #(
    parameter int unsigned INST_W   = 8,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned STATE_W  = 8,
    parameter int unsigned CYCLE_W  = 4
);
    logic [INST_W-1:0]   instruction;
    logic                stall;
    logic                flag_z;
`ifdef CTRL_IRQ_EN
    logic                irq;
    logic                irq_ack;
`endif
    logic [STATE_W-1:0]  state;
    logic [CYCLE_W-1:0]  cycle;
    logic [OPCODE_W-1:0] opcode;
    logic                inst_done;
    logic                halted;
    logic                illegal;

`ifdef CTRL_IRQ_EN
    // Sequencer side
    modport master (
        input  instruction, stall, flag_z, irq,
        output state, cycle, opcode, inst_done, halted, illegal, irq_ack
    );
    // Datapath side
    modport slave (
        output instruction, stall, flag_z, irq,
        input  state, cycle, opcode, inst_done, halted, illegal, irq_ack
    );
`else
    // Sequencer side
    modport master (
        input  instruction, stall, flag_z,
        output state, cycle, opcode, inst_done, halted, illegal
    );
    // Datapath side
    modport slave (
        output instruction, stall, flag_z,
        input  state, cycle, opcode, inst_done, halted, illegal
    );
`endif
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: parametrised multicycle T-state control sequencer (fluxcore).
// T1 FETCH_PC, T2 FETCH_INST (opcode latched on the T2->T3 edge), then an
// opcode-dependent tail ending in NEXT. Supports stall, JZ, illegal-opcode flag
// and a T-state watchdog. Interrupt entry is compiled in with `define CTRL_IRQ_EN.
// All outputs come straight from registers.
module control_sequencer #(
    parameter int unsigned INST_W   = 8,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned STATE_W  = 8,
    parameter int unsigned CYCLE_W  = 4,
    parameter int unsigned MAX_T    = 8
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH_PC   = 4'd1,
        S_FETCH_INST = 4'd2,
        S_ALU_EXEC   = 4'd3,
        S_ALU_OUT    = 4'd4,
        S_REG_STORE  = 4'd5,
        S_MEM_ADDR   = 4'd6,
        S_MEM_ACCESS = 4'd7,
        S_JMP_LOAD   = 4'd8,
        S_NEXT       = 4'd9,
        S_HALT       = 4'd10,
        S_IRQ_ENTER  = 4'd11
    } state_e;

    state_e              state_q,     state_d;
    logic [CYCLE_W-1:0]  cycle_q,     cycle_d;
    logic [OPCODE_W-1:0] opcode_q,    opcode_d;
    logic                inst_done_q, inst_done_d;
    logic                halted_q,    halted_d;
    logic                illegal_q,   illegal_d;
    logic                irq_ack_q,   irq_ack_d;

    logic [OPCODE_W-1:0] inst_op;
    logic [3:0]          inst_cls;
    logic [3:0]          op_cls;
    logic [CYCLE_W-1:0]  cycle_inc;
    logic                irq_req;
    logic                watchdog;
    logic                stall_hold;
    logic                set_illegal;

    assign inst_op  = bus.instruction[INST_W-1 -: OPCODE_W];
    assign inst_cls = inst_op[OPCODE_W-1 -: 4];
    assign op_cls   = opcode_q[OPCODE_W-1 -: 4];

    // T-index advances by one per T-state and saturates instead of wrapping
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CYCLE_W'(1);

`ifdef CTRL_IRQ_EN
    assign irq_req = bus.irq;
`else
    assign irq_req = 1'b0;
`endif

    // Watchdog fires on any working T-state that has reached the last legal index
    assign watchdog = (cycle_q == CYCLE_W'(MAX_T)) &&
                      (state_q != S_NEXT) && (state_q != S_HALT) &&
                      (state_q != S_IDLE) && (state_q != S_IRQ_ENTER);

    // Stall freezes the sequence everywhere except IDLE and HALT
    assign stall_hold = bus.stall && (state_q != S_IDLE) && (state_q != S_HALT);

    // Next-state, next T-index, opcode latch and flag updates
    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        opcode_d    = opcode_q;
        set_illegal = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH_PC;
                cycle_d = CYCLE_W'(1);
            end
            S_FETCH_PC: begin
                state_d = S_FETCH_INST;
                cycle_d = cycle_inc;
            end
            S_FETCH_INST: begin
                // Decode from the live bus; the same edge latches the opcode
                opcode_d = inst_op;
                cycle_d  = cycle_inc;
                case (inst_cls)
                    4'h0:                   state_d = S_NEXT;
                    4'h1:                   state_d = S_HALT;
                    4'h4, 4'h5, 4'h6, 4'h7: state_d = S_ALU_EXEC;
                    4'h8, 4'h9:             state_d = S_MEM_ADDR;
                    4'hC:                   state_d = S_JMP_LOAD;
                    4'hD:                   state_d = bus.flag_z ? S_JMP_LOAD : S_NEXT;
                    default: begin
                        state_d     = S_NEXT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_ALU_EXEC: begin
                state_d = S_ALU_OUT;
                cycle_d = cycle_inc;
            end
            S_ALU_OUT: begin
                state_d = S_REG_STORE;
                cycle_d = cycle_inc;
            end
            S_REG_STORE: begin
                state_d = S_NEXT;
                cycle_d = cycle_inc;
            end
            S_MEM_ADDR: begin
                state_d = S_MEM_ACCESS;
                cycle_d = cycle_inc;
            end
            S_MEM_ACCESS: begin
                // LD writes back to the register file, ST finishes here
                state_d = (op_cls == 4'h8) ? S_REG_STORE : S_NEXT;
                cycle_d = cycle_inc;
            end
            S_JMP_LOAD: begin
                state_d = S_NEXT;
                cycle_d = cycle_inc;
            end
            S_NEXT: begin
                if (irq_req) begin
                    state_d = S_IRQ_ENTER;
                    cycle_d = '0;
                end else begin
                    state_d = S_FETCH_PC;
                    cycle_d = CYCLE_W'(1);
                end
            end
            S_HALT: begin
                if (irq_req) begin
                    state_d = S_IRQ_ENTER;
                    cycle_d = '0;
                end
            end
            S_IRQ_ENTER: begin
                state_d = S_FETCH_PC;
                cycle_d = CYCLE_W'(1);
            end
            default: begin
                state_d = S_IDLE;
                cycle_d = '0;
            end
        endcase

        // Watchdog overrides the normal successor; the index stays at MAX_T
        if (watchdog) begin
            state_d     = S_NEXT;
            cycle_d     = cycle_q;
            set_illegal = 1'b1;
        end

        // Stall has the final word: nothing moves this clock
        if (stall_hold) begin
            state_d     = state_q;
            cycle_d     = cycle_q;
            opcode_d    = opcode_q;
            set_illegal = 1'b0;
        end

        // Pulses fire only on entry, so a stalled NEXT/IRQ_ENTER does not repeat them
        inst_done_d = (state_d == S_NEXT)      && (state_q != S_NEXT);
        irq_ack_d   = (state_d == S_IRQ_ENTER) && (state_q != S_IRQ_ENTER);
        halted_d    = (state_d == S_HALT);

        if (set_illegal) begin
            illegal_d = 1'b1;
        end else if (state_d == S_FETCH_PC) begin
            illegal_d = 1'b0;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // State, T-index, opcode and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cycle_q     <= '0;
            opcode_q    <= '0;
            inst_done_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            irq_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            opcode_q    <= opcode_d;
            inst_done_q <= inst_done_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            irq_ack_q   <= irq_ack_d;
        end
    end

    assign bus.state     = STATE_W'(state_q);
    assign bus.cycle     = cycle_q;
    assign bus.opcode    = opcode_q;
    assign bus.inst_done = inst_done_q;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;
`ifdef CTRL_IRQ_EN
    assign bus.irq_ack   = irq_ack_q;
`else
    // Without interrupt support IRQ_ENTER is unreachable and the ack has no port
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer.
// Expected per-clock observations are queued as stimulus is set up, then
// popped and compared one clock at a time. A second instance with MAX_T=4
// shares the inputs to exercise the watchdog. Build with +define+CTRL_IRQ_EN
// to include the interrupt scenarios.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] instr_drv;
    logic       stall_drv;
    logic       fz_drv;
`ifdef CTRL_IRQ_EN
    logic       irq_drv;
`endif

    always #5 clk = ~clk;

    control_sequencer_if #(.INST_W(8), .OPCODE_W(4), .STATE_W(8), .CYCLE_W(4)) bus ();
    control_sequencer_if #(.INST_W(8), .OPCODE_W(4), .STATE_W(8), .CYCLE_W(4)) bus4 ();

    assign bus.instruction  = instr_drv;
    assign bus.stall        = stall_drv;
    assign bus.flag_z       = fz_drv;
    assign bus4.instruction = instr_drv;
    assign bus4.stall       = stall_drv;
    assign bus4.flag_z      = fz_drv;
`ifdef CTRL_IRQ_EN
    assign bus.irq          = irq_drv;
    assign bus4.irq         = irq_drv;
`endif

    control_sequencer #(.INST_W(8), .OPCODE_W(4), .STATE_W(8), .CYCLE_W(4), .MAX_T(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    control_sequencer #(.INST_W(8), .OPCODE_W(4), .STATE_W(8), .CYCLE_W(4), .MAX_T(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    // Observation vector: [19:12] state [11:8] cycle [7] done [6] illegal [5] halted [4] irq_ack [3:0] opcode
    typedef struct {
        logic [19:0] v;
        logic [19:0] m;
        logic        stall_after;
        logic        irq_after;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    int errors = 0;
    int checks = 0;

    function automatic exp_t mk(input int st, input int cyc, input int op,
                                input bit done, input bit ill, input bit hlt, input bit ack);
        exp_t e;
        e.v = {8'(st), 4'(cyc), done, ill, hlt, ack, 4'(op)};
        e.m = {8'hFF, (cyc < 0) ? 4'h0 : 4'hF, 4'hF, (op < 0) ? 4'h0 : 4'hF};
        e.stall_after = 1'b0;
        e.irq_after   = 1'b0;
        return e;
    endfunction

    function automatic logic [19:0] obs_main();
        logic ack;
`ifdef CTRL_IRQ_EN
        ack = bus.irq_ack;
`else
        ack = 1'b0;
`endif
        return {bus.state, bus.cycle, bus.inst_done, bus.illegal, bus.halted, ack, bus.opcode};
    endfunction

    function automatic logic [19:0] obs_wd();
        logic ack;
`ifdef CTRL_IRQ_EN
        ack = bus4.irq_ack;
`else
        ack = 1'b0;
`endif
        return {bus4.state, bus4.cycle, bus4.inst_done, bus4.illegal, bus4.halted, ack, bus4.opcode};
    endfunction

    function automatic string fmt(input logic [19:0] v);
        return $sformatf("state=%0d cycle=%0d done=%b illegal=%b halted=%b irq_ack=%b opcode=%h",
                         v[19:12], v[11:8], v[7], v[6], v[5], v[4], v[3:0]);
    endfunction

    // Apply the inputs an entry asks for ahead of the next clock edge
    task automatic drive_after(input exp_t e);
        stall_drv = e.stall_after;
`ifdef CTRL_IRQ_EN
        irq_drv = e.irq_after;
`endif
    endtask

    task automatic test_reset();
        logic [19:0] got;
        exp_t z;
        reset = 1'b0; instr_drv = 8'h00; stall_drv = 1'b0; fz_drv = 1'b0;
`ifdef CTRL_IRQ_EN
        irq_drv = 1'b0;
`endif
        z = mk(0, 0, 0, 0, 0, 0, 0);
        #2;
        got = obs_main(); checks++;
        if (got !== z.v) begin errors++; $display("FAIL reset_main: got %s exp %s", fmt(got), fmt(z.v)); end
        got = obs_wd(); checks++;
        if (got !== z.v) begin errors++; $display("FAIL reset_wdog: got %s exp %s", fmt(got), fmt(z.v)); end
        @(posedge clk); #1;
        got = obs_main(); checks++;
        if (got !== z.v) begin errors++; $display("FAIL reset_held: got %s exp %s", fmt(got), fmt(z.v)); end
        reset = 1'b1;
    endtask

    task automatic test_alu();
        exp_t e, e4;
        logic [19:0] got;
        instr_drv = 8'h40;
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(2, 2, 0, 0, 0, 0, 0));
        q.push_back(mk(3, 3, 4, 0, 0, 0, 0));
        q.push_back(mk(4, 4, 4, 0, 0, 0, 0));
        q.push_back(mk(5, 5, 4, 0, 0, 0, 0));
        q.push_back(mk(9, 6, 4, 1, 0, 0, 0));
        // MAX_T=4 instance: forced NEXT right after cycle 4, illegal until the next T1
        q4.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        q4.push_back(mk(2, 2, 0, 0, 0, 0, 0));
        q4.push_back(mk(3, 3, 4, 0, 0, 0, 0));
        q4.push_back(mk(4, 4, 4, 0, 0, 0, 0));
        q4.push_back(mk(9, -1, 4, 1, 1, 0, 0));
        q4.push_back(mk(1, 1, 4, 0, 0, 0, 0));
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front(); got = obs_main(); checks++;
            if (((got ^ e.v) & e.m) !== '0) begin
                errors++; $display("FAIL alu: got %s exp %s", fmt(got), fmt(e.v));
            end
            if (q4.size() > 0) begin
                e4 = q4.pop_front(); got = obs_wd(); checks++;
                if (((got ^ e4.v) & e4.m) !== '0) begin
                    errors++; $display("FAIL watchdog: got %s exp %s", fmt(got), fmt(e4.v));
                end
            end
            drive_after(e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [19:0] got;
        logic [7:0] prog [3];
        prog = '{8'h00, 8'h90, 8'hC0};
        for (int k = 0; k < 3; k++) begin
            instr_drv = prog[k];
            case (k)
                0: begin
                    q.push_back(mk(1, 1, 4, 0, 0, 0, 0));
                    q.push_back(mk(2, 2, 4, 0, 0, 0, 0));
                    q.push_back(mk(9, 3, 0, 1, 0, 0, 0));
                end
                1: begin
                    q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                    q.push_back(mk(2, 2, 0, 0, 0, 0, 0));
                    q.push_back(mk(6, 3, 9, 0, 0, 0, 0));
                    q.push_back(mk(7, 4, 9, 0, 0, 0, 0));
                    q.push_back(mk(9, 5, 9, 1, 0, 0, 0));
                end
                default: begin
                    q.push_back(mk(1, 1, 9, 0, 0, 0, 0));
                    q.push_back(mk(2, 2, 9, 0, 0, 0, 0));
                    q.push_back(mk(8, 3, 12, 0, 0, 0, 0));
                    q.push_back(mk(9, 4, 12, 1, 0, 0, 0));
                end
            endcase
            while (q.size() > 0) begin
                @(posedge clk); #1;
                e = q.pop_front(); got = obs_main(); checks++;
                if (((got ^ e.v) & e.m) !== '0) begin
                    errors++; $display("FAIL back_to_back[%0d]: got %s exp %s", k, fmt(got), fmt(e.v));
                end
                drive_after(e);
            end
        end
    endtask

    task automatic test_ld_stall();
        exp_t e;
        logic [19:0] got;
        instr_drv = 8'h80;
        q.push_back(mk(1, 1, 12, 0, 0, 0, 0));
        q.push_back(mk(2, 2, 12, 0, 0, 0, 0));
        q.push_back(mk(6, 3, 8, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            e = mk(7, 4, 8, 0, 0, 0, 0);
            e.stall_after = (k < 3);
            q.push_back(e);
        end
        q.push_back(mk(5, 5, 8, 0, 0, 0, 0));
        e = mk(9, 6, 8, 1, 0, 0, 0);
        e.stall_after = 1'b1;
        q.push_back(e);
        q.push_back(mk(9, 6, 8, 0, 0, 0, 0));
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front(); got = obs_main(); checks++;
            if (((got ^ e.v) & e.m) !== '0) begin
                errors++; $display("FAIL ld_stall: got %s exp %s", fmt(got), fmt(e.v));
            end
            drive_after(e);
        end
    endtask

    task automatic test_jz();
        exp_t e;
        logic [19:0] got;
        for (int k = 0; k < 2; k++) begin
            instr_drv = 8'hD0;
            fz_drv = (k == 0);
            q.push_back(mk(1, 1, (k == 0) ? 8 : 13, 0, 0, 0, 0));
            q.push_back(mk(2, 2, (k == 0) ? 8 : 13, 0, 0, 0, 0));
            if (k == 0) begin
                q.push_back(mk(8, 3, 13, 0, 0, 0, 0));
                q.push_back(mk(9, 4, 13, 1, 0, 0, 0));
            end else begin
                q.push_back(mk(9, 3, 13, 1, 0, 0, 0));
            end
            while (q.size() > 0) begin
                @(posedge clk); #1;
                e = q.pop_front(); got = obs_main(); checks++;
                if (((got ^ e.v) & e.m) !== '0) begin
                    errors++; $display("FAIL jz_fz%0d: got %s exp %s", (k == 0), fmt(got), fmt(e.v));
                end
                drive_after(e);
            end
        end
        fz_drv = 1'b0;
    endtask

    task automatic test_illegal();
        exp_t e;
        logic [19:0] got;
        logic [7:0] prog [3];
        logic [3:0] prev;
        prog = '{8'hA0, 8'h30, 8'h00};
        prev = 4'hD;
        for (int k = 0; k < 3; k++) begin
            instr_drv = prog[k];
            q.push_back(mk(1, 1, int'(prev), 0, 0, 0, 0));
            q.push_back(mk(2, 2, int'(prev), 0, 0, 0, 0));
            e = mk(9, 3, int'(prog[k][7:4]), 1, (k < 2), 0, 0);
            e.stall_after = (k == 0);
            q.push_back(e);
            if (k == 0) q.push_back(mk(9, 3, 10, 0, 1, 0, 0));
            prev = prog[k][7:4];
            while (q.size() > 0) begin
                @(posedge clk); #1;
                e = q.pop_front(); got = obs_main(); checks++;
                if (((got ^ e.v) & e.m) !== '0) begin
                    errors++; $display("FAIL illegal[%0d]: got %s exp %s", k, fmt(got), fmt(e.v));
                end
                drive_after(e);
            end
        end
    endtask

`ifdef CTRL_IRQ_EN
    task automatic test_irq_wait();
        exp_t e;
        logic [19:0] got;
        instr_drv = 8'h50;
        irq_drv = 1'b1;
        e = mk(1, 1, 0, 0, 0, 0, 0); e.irq_after = 1'b1; q.push_back(e);
        e = mk(2, 2, 0, 0, 0, 0, 0); e.irq_after = 1'b1; q.push_back(e);
        e = mk(3, 3, 5, 0, 0, 0, 0); e.irq_after = 1'b1; q.push_back(e);
        e = mk(4, 4, 5, 0, 0, 0, 0); e.irq_after = 1'b1; q.push_back(e);
        e = mk(5, 5, 5, 0, 0, 0, 0); e.irq_after = 1'b1; q.push_back(e);
        e = mk(9, 6, 5, 1, 0, 0, 0); e.irq_after = 1'b1; q.push_back(e);
        q.push_back(mk(11, 0, 5, 0, 0, 0, 1));
        q.push_back(mk(1, 1, 5, 0, 0, 0, 0));
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front(); got = obs_main(); checks++;
            if (((got ^ e.v) & e.m) !== '0) begin
                errors++; $display("FAIL irq_wait: got %s exp %s", fmt(got), fmt(e.v));
            end
            drive_after(e);
        end
    endtask
`endif

    task automatic test_halt();
        exp_t e;
        logic [19:0] got;
        instr_drv = 8'h10;
`ifdef CTRL_IRQ_EN
        // Previous test leaves the sequencer in T1, so no fresh T1 entry here
        q.push_back(mk(2, 2, -1, 0, 0, 0, 0));
`else
        q.push_back(mk(1, 1, -1, 0, 0, 0, 0));
        q.push_back(mk(2, 2, -1, 0, 0, 0, 0));
`endif
        for (int k = 0; k < 21; k++) begin
            e = mk(10, 3, 1, 0, 0, 1, 0);
            // Stall toggles while halted and must have no effect
            e.stall_after = (k % 3 == 1) && (k < 20);
`ifdef CTRL_IRQ_EN
            e.irq_after = (k == 20);
`endif
            q.push_back(e);
        end
`ifdef CTRL_IRQ_EN
        q.push_back(mk(11, 0, 1, 0, 0, 0, 1));
        q.push_back(mk(1, 1, 1, 0, 0, 0, 0));
`endif
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front(); got = obs_main(); checks++;
            if (((got ^ e.v) & e.m) !== '0) begin
                errors++; $display("FAIL halt: got %s exp %s", fmt(got), fmt(e.v));
            end
            drive_after(e);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, z;
        logic [19:0] got;
        z = mk(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        got = obs_main(); checks++;
        if (got !== z.v) begin errors++; $display("FAIL reset_exit: got %s exp %s", fmt(got), fmt(z.v)); end
        @(posedge clk); #1;
        reset = 1'b1;
        instr_drv = 8'h40;
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(2, 2, 0, 0, 0, 0, 0));
        q.push_back(mk(3, 3, 4, 0, 0, 0, 0));
        q.push_back(mk(4, 4, 4, 0, 0, 0, 0));
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front(); got = obs_main(); checks++;
            if (((got ^ e.v) & e.m) !== '0) begin
                errors++; $display("FAIL reset_mid_run: got %s exp %s", fmt(got), fmt(e.v));
            end
            drive_after(e);
        end
        // Abort in the middle of ALU_OUT, between clock edges
        #3;
        reset = 1'b0;
        #1;
        got = obs_main(); checks++;
        if (got !== z.v) begin errors++; $display("FAIL reset_mid_abort: got %s exp %s", fmt(got), fmt(z.v)); end
        got = obs_wd(); checks++;
        if (got !== z.v) begin errors++; $display("FAIL reset_mid_wdog: got %s exp %s", fmt(got), fmt(z.v)); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_ld_stall();
        test_jz();
        test_illegal();
`ifdef CTRL_IRQ_EN
        test_irq_wait();
`endif
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
